// File: rtl/register_read_stage_if.sv
// Handshake bundle between decode, the register-read stage and execute.
// The stage sits on the slave side; the decode/execute environment drives
// the master side.
interface register_read_stage_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int SEL_WIDTH     = 4,
    parameter int PAYLOAD_WIDTH = 64
);
    // Decode -> stage
    logic                     in_valid;
    logic                     in_ready;
    logic [SEL_WIDTH-1:0]     in_sel_ra;
    logic [SEL_WIDTH-1:0]     in_sel_rb;
    logic [SEL_WIDTH-1:0]     in_sel_rc;
    logic                     in_dest_en;
    logic [SEL_WIDTH-1:0]     in_dest_sel;
    logic [PAYLOAD_WIDTH-1:0] in_payload;

    // Stage -> execute
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_WIDTH-1:0]    out_data_ra;
    logic [DATA_WIDTH-1:0]    out_data_rb;
    logic [DATA_WIDTH-1:0]    out_data_rc;
    logic [PAYLOAD_WIDTH-1:0] out_payload;

    modport slave (
        input  in_valid, in_sel_ra, in_sel_rb, in_sel_rc,
               in_dest_en, in_dest_sel, in_payload, out_ready,
        output in_ready, out_valid, out_data_ra, out_data_rb, out_data_rc,
               out_payload
    );

    modport master (
        output in_valid, in_sel_ra, in_sel_rb, in_sel_rc,
               in_dest_en, in_dest_sel, in_payload, out_ready,
        input  in_ready, out_valid, out_data_ra, out_data_rb, out_data_rc,
               out_payload
    );
endinterface

// File: rtl/register_read_stage.sv
// Register-read pipeline stage.
// Drives the register file's three synchronous read ports, tracks registers
// with an outstanding write in a pending scoreboard, stalls decode on RAW/WAW
// hazards, and forwards operands plus payload to execute one cycle after
// acceptance. A hold buffer keeps operands stable under execute back-pressure,
// because the register file output is only valid in the cycle after a read.
module register_read_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_REGS      = 16,
    parameter int SEL_WIDTH     = 4,
    parameter int PAYLOAD_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    register_read_stage_if.slave  bus,
    output logic [SEL_WIDTH-1:0]  rf_read_sel_ra,
    output logic [SEL_WIDTH-1:0]  rf_read_sel_rb,
    output logic [SEL_WIDTH-1:0]  rf_read_sel_rc,
    input  logic [DATA_WIDTH-1:0] rf_read_data_ra,
    input  logic [DATA_WIDTH-1:0] rf_read_data_rb,
    input  logic [DATA_WIDTH-1:0] rf_read_data_rc,
    input  logic                  wb_en,
    input  logic [SEL_WIDTH-1:0]  wb_sel
);

    // IDLE: nothing for execute. LIVE: operands come straight from the
    // register file read data. HELD: operands come from the hold registers.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LIVE = 2'd1,
        ST_HELD = 2'd2
    } state_t;

    state_t                   state_r;
    state_t                   state_nxt_s;

    logic [NUM_REGS-1:0]      pending_r;
    logic [NUM_REGS-1:0]      pending_nxt_s;
    logic [NUM_REGS-1:0]      clr_mask_s;
    logic [NUM_REGS-1:0]      set_mask_s;
    logic [NUM_REGS-1:0]      pend_eff_s;

    logic                     hazard_s;
    logic                     in_ready_s;
    logic                     accept_s;

    logic [SEL_WIDTH-1:0]     sel_ra_r;
    logic [SEL_WIDTH-1:0]     sel_rb_r;
    logic [SEL_WIDTH-1:0]     sel_rc_r;

    logic [PAYLOAD_WIDTH-1:0] payload_r;
    logic [DATA_WIDTH-1:0]    hold_ra_r;
    logic [DATA_WIDTH-1:0]    hold_rb_r;
    logic [DATA_WIDTH-1:0]    hold_rc_r;

    logic                     out_valid_s;
    logic [DATA_WIDTH-1:0]    out_data_ra_s;
    logic [DATA_WIDTH-1:0]    out_data_rb_s;
    logic [DATA_WIDTH-1:0]    out_data_rc_s;

    // One-hot scoreboard mask for a register select; register 0 is never
    // tracked, so it always yields an empty mask.
    function automatic logic [NUM_REGS-1:0] reg_mask(
        input logic                 en,
        input logic [SEL_WIDTH-1:0] sel
    );
        logic [NUM_REGS-1:0] m;
        m = {NUM_REGS{1'b0}};
        if (en && (sel != {SEL_WIDTH{1'b0}})) begin
            m[sel] = 1'b1;
        end else begin
            m = {NUM_REGS{1'b0}};
        end
        return m;
    endfunction

    // True when a select refers to a register that still awaits a write.
    function automatic logic reg_busy(
        input logic [NUM_REGS-1:0]  pend,
        input logic [SEL_WIDTH-1:0] sel
    );
        return (sel != {SEL_WIDTH{1'b0}}) && pend[sel];
    endfunction

    // Scoreboard view for this cycle: a writeback retires its bit before the
    // hazard check so an instruction can issue in the writeback cycle.
    always_comb begin
        clr_mask_s = reg_mask(wb_en, wb_sel);
        pend_eff_s = pending_r & ~clr_mask_s;
        hazard_s   = reg_busy(pend_eff_s, bus.in_sel_ra)
                   | reg_busy(pend_eff_s, bus.in_sel_rb)
                   | reg_busy(pend_eff_s, bus.in_sel_rc)
                   | (bus.in_dest_en & reg_busy(pend_eff_s, bus.in_dest_sel));
    end

    // Accept when hazard-free and the output slot is empty or draining.
    always_comb begin
        in_ready_s    = ~hazard_s & ((state_r == ST_IDLE) | bus.out_ready);
        accept_s      = bus.in_valid & in_ready_s;
        set_mask_s    = reg_mask(accept_s & bus.in_dest_en, bus.in_dest_sel);
        // A new destination claim overrides a same-cycle retire of that bit.
        pending_nxt_s = pend_eff_s | set_mask_s;
    end

    // Pending-write scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r <= {NUM_REGS{1'b0}};
        end else begin
            pending_r <= pending_nxt_s;
        end
    end

    // Remember the last accepted selects so the read ports stay parked on them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_ra_r <= {SEL_WIDTH{1'b0}};
            sel_rb_r <= {SEL_WIDTH{1'b0}};
            sel_rc_r <= {SEL_WIDTH{1'b0}};
        end else if (accept_s) begin
            sel_ra_r <= bus.in_sel_ra;
            sel_rb_r <= bus.in_sel_rb;
            sel_rc_r <= bus.in_sel_rc;
        end
    end

    // Read ports follow decode on accept so data arrives in the next cycle.
    always_comb begin
        if (accept_s) begin
            rf_read_sel_ra = bus.in_sel_ra;
            rf_read_sel_rb = bus.in_sel_rb;
            rf_read_sel_rc = bus.in_sel_rc;
        end else begin
            rf_read_sel_ra = sel_ra_r;
            rf_read_sel_rb = sel_rb_r;
            rf_read_sel_rc = sel_rc_r;
        end
    end

    // Capture the payload alongside the register read it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            payload_r <= {PAYLOAD_WIDTH{1'b0}};
        end else if (accept_s) begin
            payload_r <= bus.in_payload;
        end
    end

    // Freeze the read data the first cycle execute refuses it; the register
    // file output is not guaranteed to stay put afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_ra_r <= {DATA_WIDTH{1'b0}};
            hold_rb_r <= {DATA_WIDTH{1'b0}};
            hold_rc_r <= {DATA_WIDTH{1'b0}};
        end else if ((state_r == ST_LIVE) && !bus.out_ready) begin
            hold_ra_r <= rf_read_data_ra;
            hold_rb_r <= rf_read_data_rb;
            hold_rc_r <= rf_read_data_rc;
        end
    end

    // Output-slot state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Output-slot next state; LIVE and HELD drain identically.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_LIVE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LIVE, ST_HELD: begin
                if (!bus.out_ready) begin
                    state_nxt_s = ST_HELD;
                end else if (accept_s) begin
                    state_nxt_s = ST_LIVE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Operand source select: read data while LIVE, hold buffer while HELD.
    always_comb begin
        out_valid_s   = 1'b0;
        out_data_ra_s = rf_read_data_ra;
        out_data_rb_s = rf_read_data_rb;
        out_data_rc_s = rf_read_data_rc;
        case (state_r)
            ST_IDLE: begin
                out_valid_s = 1'b0;
            end
            ST_LIVE: begin
                out_valid_s = 1'b1;
            end
            ST_HELD: begin
                out_valid_s   = 1'b1;
                out_data_ra_s = hold_ra_r;
                out_data_rb_s = hold_rb_r;
                out_data_rc_s = hold_rc_r;
            end
            default: begin
                out_valid_s = 1'b0;
            end
        endcase
    end

    assign bus.in_ready    = in_ready_s;
    assign bus.out_valid   = out_valid_s;
    assign bus.out_data_ra = out_data_ra_s;
    assign bus.out_data_rb = out_data_rb_s;
    assign bus.out_data_rc = out_data_rc_s;
    assign bus.out_payload = payload_r;

endmodule

// File: tb/tb_register_read_stage.sv
// Testbench for register_read_stage: table of single-issue vectors, directed
// hazard/back-pressure/reset sequences, then randomized traffic checked
// against a transaction-level model (pending set + one-deep output queue).
module tb_register_read_stage;

    localparam int DW = 32;
    localparam int NR = 16;
    localparam int SW = 4;
    localparam int PW = 64;
    localparam int NV = 6;
    localparam int N_RAND = 2000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    register_read_stage_if #(.DATA_WIDTH(DW), .SEL_WIDTH(SW), .PAYLOAD_WIDTH(PW)) bus ();

    logic [SW-1:0] rf_read_sel_ra, rf_read_sel_rb, rf_read_sel_rc;
    logic [DW-1:0] rf_read_data_ra, rf_read_data_rb, rf_read_data_rc;
    logic          wb_en;
    logic [SW-1:0] wb_sel;
    logic [DW-1:0] wb_data;
    logic          rf_load;
    logic [DW-1:0] rf_mem [NR];

    register_read_stage #(
        .DATA_WIDTH(DW), .NUM_REGS(NR), .SEL_WIDTH(SW), .PAYLOAD_WIDTH(PW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .rf_read_sel_ra(rf_read_sel_ra), .rf_read_sel_rb(rf_read_sel_rb),
        .rf_read_sel_rc(rf_read_sel_rc),
        .rf_read_data_ra(rf_read_data_ra), .rf_read_data_rb(rf_read_data_rb),
        .rf_read_data_rc(rf_read_data_rc),
        .wb_en(wb_en), .wb_sel(wb_sel)
    );

    // Register file stub: synchronous read with same-cycle write bypass.
    function automatic logic [DW-1:0] rf_rd(input logic [SW-1:0] s);
        if (s == 4'd0) return 32'd0;
        if (wb_en && wb_sel == s) return wb_data;
        return rf_mem[s];
    endfunction

    always @(posedge clk) begin
        rf_read_data_ra <= rf_rd(rf_read_sel_ra);
        rf_read_data_rb <= rf_rd(rf_read_sel_rb);
        rf_read_data_rc <= rf_rd(rf_read_sel_rc);
        if (rf_load) begin
            for (int i = 0; i < NR; i++) rf_mem[i] <= 32'(i * 32'h11);
        end else if (wb_en && wb_sel != 4'd0) begin
            rf_mem[wb_sel] <= wb_data;
        end
    end

    int n_checks;
    int n_pass;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic drive(input logic v, input logic [SW-1:0] ra, input logic [SW-1:0] rb,
                         input logic [SW-1:0] rc, input logic de, input logic [SW-1:0] ds,
                         input logic [PW-1:0] pl);
        bus.in_valid    = v;
        bus.in_sel_ra   = ra;
        bus.in_sel_rb   = rb;
        bus.in_sel_rc   = rc;
        bus.in_dest_en  = de;
        bus.in_dest_sel = ds;
        bus.in_payload  = pl;
    endtask

    task automatic set_wb(input logic en, input logic [SW-1:0] s, input logic [DW-1:0] d);
        wb_en   = en;
        wb_sel  = s;
        wb_data = d;
    endtask

    task automatic check_out(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input logic [DW-1:0] c, input logic [PW-1:0] pl);
        check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        check({tag, "_ra"}, 64'(bus.out_data_ra), 64'(a));
        check({tag, "_rb"}, 64'(bus.out_data_rb), 64'(b));
        check({tag, "_rc"}, 64'(bus.out_data_rc), 64'(c));
        check({tag, "_payload"}, bus.out_payload, pl);
    endtask

    typedef struct {
        logic [SW-1:0] ra, rb, rc;
        logic          de;
        logic [SW-1:0] ds;
        logic [PW-1:0] pl;
        logic          exp_ready;
        logic [DW-1:0] xa, xb, xc;
    } vec_t;

    function automatic vec_t mk(input logic [SW-1:0] ra, input logic [SW-1:0] rb,
                                input logic [SW-1:0] rc, input logic de, input logic [SW-1:0] ds,
                                input logic [PW-1:0] pl, input logic er,
                                input logic [DW-1:0] xa, input logic [DW-1:0] xb,
                                input logic [DW-1:0] xc);
        vec_t v;
        v.ra = ra; v.rb = rb; v.rc = rc; v.de = de; v.ds = ds; v.pl = pl;
        v.exp_ready = er; v.xa = xa; v.xb = xb; v.xc = xc;
        return v;
    endfunction

    // Reference model: pending register set and a one-deep queue of
    // transactions promised to execute.
    typedef struct packed {
        logic [DW-1:0] a, b, c;
        logic [PW-1:0] pl;
    } txn_t;

    txn_t          m_q [$];
    txn_t          t;
    logic [NR-1:0] m_pend;
    logic [NR-1:0] pe;
    logic          haz, exp_rdy, acc, found;
    int            pick;
    vec_t          vt [NV];
    logic [DW-1:0] r7_data;

    // Value register r will hold after this cycle's writeback.
    function automatic logic [DW-1:0] m_val(input logic [SW-1:0] r);
        if (r == 4'd0) return 32'd0;
        if (wb_en && wb_sel == r) return wb_data;
        return rf_mem[r];
    endfunction

    function automatic logic m_blocked(input logic [NR-1:0] p, input logic [SW-1:0] r);
        return (r != 4'd0) && p[r];
    endfunction

    initial begin
        n_checks = 0;
        n_pass   = 0;
        m_pend   = 16'd0;
        drive(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 64'd0);
        bus.out_ready = 1'b1;
        set_wb(1'b0, 4'd0, 32'd0);
        rf_load = 1'b1;

        vt[0] = mk(4'd1,  4'd2,  4'd0,  1'b0, 4'd0, 64'h1, 1'b1, 32'h11, 32'h22, 32'h0);
        vt[1] = mk(4'd3,  4'd4,  4'd5,  1'b0, 4'd0, 64'h2, 1'b1, 32'h33, 32'h44, 32'h55);
        vt[2] = mk(4'd15, 4'd15, 4'd14, 1'b0, 4'd0, 64'hFEED_0000_0000_0003, 1'b1,
                   32'hFF, 32'hFF, 32'hEE);
        vt[3] = mk(4'd0,  4'd0,  4'd0,  1'b1, 4'd0, 64'h4, 1'b1, 32'h0, 32'h0, 32'h0);
        vt[4] = mk(4'd0,  4'd7,  4'd0,  1'b1, 4'd0, 64'h5, 1'b1, 32'h0, 32'h77, 32'h0);
        vt[5] = mk(4'd9,  4'd10, 4'd11, 1'b0, 4'd0, 64'h6, 1'b1, 32'h99, 32'hAA, 32'hBB);

        // Reset values are visible before any clock edge.
        #2;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_payload", bus.out_payload, 64'd0);
        check("rst_sel_ra", 64'(rf_read_sel_ra), 64'd0);
        check("rst_sel_rc", 64'(rf_read_sel_rc), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rf_load = 1'b0;
        rst_n   = 1'b1;
        #1;
        check("idle_out_valid", 64'(bus.out_valid), 64'd0);
        check("idle_in_ready", 64'(bus.in_ready), 64'd1);

        // Table: back-to-back issue, out_ready high throughout.
        for (int i = 0; i <= NV; i++) begin
            @(negedge clk);
            if (i < NV) drive(1'b1, vt[i].ra, vt[i].rb, vt[i].rc, vt[i].de, vt[i].ds, vt[i].pl);
            else bus.in_valid = 1'b0;
            #1;
            if (i < NV) check("tbl_in_ready", 64'(bus.in_ready), 64'(vt[i].exp_ready));
            if (i > 0) check_out("tbl", vt[i-1].xa, vt[i-1].xb, vt[i-1].xc, vt[i-1].pl);
        end
        @(negedge clk); #1;
        check("tbl_drained", 64'(bus.out_valid), 64'd0);

        // RAW stall on r5 until its writeback; issue in the writeback cycle.
        @(negedge clk);
        drive(1'b1, 4'd0, 4'd0, 4'd0, 1'b1, 4'd5, 64'hA5); #1;
        check("raw_dest_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        drive(1'b1, 4'd5, 4'd0, 4'd0, 1'b0, 4'd0, 64'hB6); #1;
        check("raw_stall0", 64'(bus.in_ready), 64'd0);
        @(negedge clk); #1;
        check("raw_stall1", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        set_wb(1'b1, 4'd5, 32'hABCD); #1;
        check("raw_wb_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        set_wb(1'b0, 4'd0, 32'd0);
        bus.in_valid = 1'b0; #1;
        check_out("raw_bypass", 32'hABCD, 32'h0, 32'h0, 64'hB6);

        // Claim on r3 wins over a same-cycle retire of r3.
        @(negedge clk);
        drive(1'b1, 4'd0, 4'd0, 4'd0, 1'b1, 4'd3, 64'h31); #1;
        check("sw_first_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        drive(1'b1, 4'd0, 4'd0, 4'd0, 1'b1, 4'd3, 64'h32);
        set_wb(1'b1, 4'd3, 32'h333); #1;
        check("sw_waw_retire_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        set_wb(1'b0, 4'd0, 32'd0);
        drive(1'b1, 4'd3, 4'd0, 4'd0, 1'b0, 4'd0, 64'h33); #1;
        check("sw_still_pending0", 64'(bus.in_ready), 64'd0);
        @(negedge clk); #1;
        check("sw_still_pending1", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        set_wb(1'b1, 4'd3, 32'h3030); #1;
        check("sw_release", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        set_wb(1'b0, 4'd0, 32'd0);
        bus.in_valid = 1'b0; #1;
        check_out("sw_data", 32'h3030, 32'h0, 32'h0, 64'h33);

        // Back-pressure: four cycles of out_ready low, unrelated r7 writes.
        @(negedge clk);
        drive(1'b1, 4'd1, 4'd2, 4'd0, 1'b0, 4'd0, 64'hCAFE); #1;
        check("bp_accept", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        drive(1'b1, 4'd6, 4'd0, 4'd0, 1'b0, 4'd0, 64'hD00D);
        bus.out_ready = 1'b0; #1;
        check_out("bp_live", 32'h11, 32'h22, 32'h0, 64'hCAFE);
        check("bp_live_stall", 64'(bus.in_ready), 64'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            r7_data = $urandom;
            set_wb(1'b1, 4'd7, r7_data);
            if (k == 3) set_wb(1'b0, 4'd0, 32'd0);
            #1;
            check_out("bp_held", 32'h11, 32'h22, 32'h0, 64'hCAFE);
            check("bp_held_stall", 64'(bus.in_ready), 64'd0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1; #1;
        check("bp_drain_ready", 64'(bus.in_ready), 64'd1);
        check_out("bp_drain", 32'h11, 32'h22, 32'h0, 64'hCAFE);
        @(negedge clk);
        bus.in_valid = 1'b0; #1;
        check_out("bp_next", 32'h66, 32'h0, 32'h0, 64'hD00D);
        @(negedge clk); #1;
        check("bp_idle", 64'(bus.out_valid), 64'd0);

        // Reset while HELD with r4 pending.
        @(negedge clk);
        drive(1'b1, 4'd0, 4'd0, 4'd0, 1'b1, 4'd4, 64'hEE);
        bus.out_ready = 1'b0; #1;
        check("rh_accept", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0; #1;
        check("rh_live", 64'(bus.out_valid), 64'd1);
        @(negedge clk); #1;
        check("rh_held", 64'(bus.out_valid), 64'd1);
        @(negedge clk);
        rst_n = 1'b0; #1;
        check("rh_rst_valid", 64'(bus.out_valid), 64'd0);
        check("rh_rst_payload", bus.out_payload, 64'd0);
        check("rh_rst_sel", 64'(rf_read_sel_ra), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        drive(1'b1, 4'd4, 4'd0, 4'd0, 1'b0, 4'd0, 64'h44); #1;
        check("rh_r4_no_stall", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0; #1;
        check_out("rh_r4", 32'h44, 32'h0, 32'h0, 64'h44);
        @(negedge clk); #1;
        check("rh_idle", 64'(bus.out_valid), 64'd0);

        // Randomized traffic against the transaction model.
        m_pend = 16'd0;
        for (int n = 0; n < N_RAND; n++) begin
            @(negedge clk);
            drive(1'($urandom_range(0, 3) != 0), SW'($urandom_range(0, 7)),
                  SW'($urandom_range(0, 7)), SW'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), SW'($urandom_range(0, 7)),
                  {32'($urandom), 32'($urandom)});
            bus.out_ready = 1'($urandom_range(0, 3) != 0);
            wb_en   = 1'($urandom_range(0, 1));
            wb_data = 32'($urandom);
            wb_sel  = SW'($urandom_range(0, 7));
            found   = 1'b0;
            pick    = int'($urandom_range(1, NR - 1));
            if (m_pend != 16'd0 && $urandom_range(0, 2) != 0) begin
                for (int k = 0; k < NR; k++) begin
                    if (!found && m_pend[(pick + k) % NR]) begin
                        wb_sel = SW'((pick + k) % NR);
                        found  = 1'b1;
                    end
                end
            end
            #1;
            pe = m_pend;
            if (wb_en && wb_sel != 4'd0) pe[wb_sel] = 1'b0;
            haz = m_blocked(pe, bus.in_sel_ra) || m_blocked(pe, bus.in_sel_rb) ||
                  m_blocked(pe, bus.in_sel_rc) ||
                  (bus.in_dest_en && m_blocked(pe, bus.in_dest_sel));
            exp_rdy = !haz && (m_q.size() == 0 || bus.out_ready);
            check("rnd_in_ready", 64'(bus.in_ready), 64'(exp_rdy));
            check("rnd_out_valid", 64'(bus.out_valid), 64'(m_q.size() != 0));
            if (m_q.size() != 0) check_out("rnd", m_q[0].a, m_q[0].b, m_q[0].c, m_q[0].pl);
            acc = bus.in_valid && exp_rdy;
            if (acc) begin
                check("rnd_sel_ra", 64'(rf_read_sel_ra), 64'(bus.in_sel_ra));
                check("rnd_sel_rb", 64'(rf_read_sel_rb), 64'(bus.in_sel_rb));
                check("rnd_sel_rc", 64'(rf_read_sel_rc), 64'(bus.in_sel_rc));
            end
            if (m_q.size() != 0 && bus.out_ready) void'(m_q.pop_front());
            if (acc) begin
                t.a  = m_val(bus.in_sel_ra);
                t.b  = m_val(bus.in_sel_rb);
                t.c  = m_val(bus.in_sel_rc);
                t.pl = bus.in_payload;
                m_q.push_back(t);
                if (bus.in_dest_en && bus.in_dest_sel != 4'd0) pe[bus.in_dest_sel] = 1'b1;
            end
            m_pend = pe;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/register_read_stage.md
Name: register_read_stage

Overview:
- Pipeline stage directly upstream of the execute stage; it drives the register file's three synchronous read ports and consumes the read data one cycle later.
- Holds a 16-bit pending-write scoreboard and stalls decode on RAW/WAW hazards.
- Presents operands plus an opaque instruction payload to execute over a valid/ready handshake, with a hold buffer for downstream back-pressure.

Parameters:
- DATA_WIDTH, 32, register data width
- NUM_REGS, 16, register count; register 0 hardwired zero, never tracked
- SEL_WIDTH, 4, register select width (log2 NUM_REGS)
- PAYLOAD_WIDTH, 64, opaque decoded-instruction bits passed through

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decode offers instruction
- in_ready  out  1  stage accepts this cycle
- in_sel_ra, in_sel_rb, in_sel_rc  in  SEL_WIDTH each  source selects
- in_dest_en  in  1  instruction writes a register
- in_dest_sel  in  SEL_WIDTH  destination select
- in_payload  in  PAYLOAD_WIDTH  passthrough bits
- rf_read_sel_ra, rf_read_sel_rb, rf_read_sel_rc  out  SEL_WIDTH each  to register file
- rf_read_data_ra, rf_read_data_rb, rf_read_data_rc  in  DATA_WIDTH each  from register file, valid one cycle after select
- wb_en  in  1  writeback strobe (same signal also drives register file write)
- wb_sel  in  SEL_WIDTH  writeback select
- out_valid  out  1  operands valid to execute
- out_ready  in  1  execute accepts
- out_data_ra, out_data_rb, out_data_rc  out  DATA_WIDTH each  operands
- out_payload  out  PAYLOAD_WIDTH  passthrough bits

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE, scoreboard all 0, out_valid 0
  - out_payload and hold registers 0, rf selects 0
  - Outputs take these values immediately and remain so until the first clk edge after rst_n rises.
- Scoreboard:
  - clr = wb_en && wb_sel!=0 clears bit wb_sel.
  - pend_eff = pending & ~clr.
  - hazard = any of ra/rb/rc or (in_dest_en ? in_dest_sel : none) maps to a set pend_eff bit; select 0 never hazards.
- Acceptance:
  - in_ready = !hazard && (state==IDLE || out_ready).
  - accept = in_valid && in_ready.
  - On accept with in_dest_en && in_dest_sel!=0, set that bit. Set wins over a same-cycle clear of the same bit.
- rf selects:
  - On accept, rf_read_sel_* = in_sel_* combinationally.
  - Otherwise hold the last accepted selects.
  - The register file's same-cycle write bypass covers a writeback that clears a source in the accept cycle.
- Latency: one cycle from accept to out_valid.
- States:
  - IDLE: out_valid=0.
    - accept -> LIVE.
  - LIVE: out_valid=1; out_data_* = rf_read_data_* (direct); payload from register captured at accept.
    - out_ready && accept -> LIVE.
    - out_ready && !accept -> IDLE.
    - !out_ready -> HELD, capturing rf_read_data_* into hold registers.
  - HELD: out_valid=1; out_data_* = hold registers.
    - out_ready && accept -> LIVE.
    - out_ready && !accept -> IDLE.
    - else stay in HELD.
- out_valid and out_data_* are stable while out_valid && !out_ready; no operand changes under a held transfer.
- Writebacks never alter a held operand; the hazard check guarantees no sources are pending.
- Reset mid-operation discards the in-flight instruction and all scoreboard bits; no out_valid pulse follows.

Test Plan:
- Accept ra=1, rb=2, rc=0 with rf holding r1=0x11, r2=0x22; out_ready=1 -> out_valid one cycle later with data 0x11/0x22/0x0; in_ready stays 1 back-to-back.
- Accept dest r5, then next instr reads r5 -> in_ready=0 until wb_en, wb_sel=5, wb_data=0xABCD. Accept in that wb cycle; operand ra=0xABCD next cycle.
- Accept dest r3 while wb clears r3 same cycle -> scoreboard bit 3 remains 1; a following read of r3 stalls.
- Hold out_ready=0 for 4 cycles after out_valid -> state HELD; operands and payload constant. Writes to an unrelated r7 leave operands unchanged. out_ready=1 drains; in_ready asserted in the same cycle.
- Dest r0 with in_dest_en=1 -> no scoreboard bit set; subsequent reads of r0 never stall.
- Assert rst_n=0 while in HELD with r4 pending -> out_valid=0 immediately; after release, a read of r4 is accepted without stall.
